// File: rtl/flash_burst_slave.sv
// rtl/flash_burst_slave.sv - Wishbone-classic slave mapping async parallel NOR flash into the bus space
// Reads are assembled from BEATS flash accesses; single writes run setup/pulse/hold for CFI commands.
module flash_burst_slave #(
    parameter int ADDR_W     = 23,
    parameter int DATA_W     = 16,
    parameter int READ_WAIT  = 6,
    parameter int WRITE_WAIT = 6,
    parameter int WRITE_EN   = 1
) (
    input  logic              clk_bus,
    input  logic              rst_bus,
    input  logic [31:0]       dat_i,
    output logic [31:0]       dat_o,
    output logic              ack_o,
    input  logic [31:0]       adr_i,
    input  logic              cyc_i,
    output logic              err_o,
    output logic              rty_o,
    input  logic [3:0]        sel_i,
    input  logic              stb_i,
    input  logic              we_i,
    output logic [ADDR_W-1:0] flash_a,
    inout  wire  [DATA_W-1:0] flash_d,
    output logic              flash_rp_n,
    output logic              flash_vpen,
    output logic              flash_ce_n,
    output logic              flash_oe_n,
    output logic              flash_we_n,
    output logic              flash_byte_n
);

    localparam int BEATS = 32 / DATA_W;
    localparam int STEP  = DATA_W / 8;
    localparam int MAXW  = (READ_WAIT > WRITE_WAIT) ? READ_WAIT : WRITE_WAIT;
    localparam int CNT_W = $clog2(MAXW + 1);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD,
        ACK,
        ERR
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  wait_cnt;
    logic [1:0]        beat;
    logic [31:0]       shadow;
    logic [31:0]       merged;
    logic [DATA_W-1:0] wdata;
    logic              drive;
    logic              unused_inputs;

    assign unused_inputs = ^{sel_i, adr_i, dat_i};

    assign rty_o        = 1'b0;
    assign flash_rp_n   = 1'b1;
    assign flash_vpen   = (WRITE_EN != 0);
    assign flash_byte_n = (DATA_W == 16);
    assign flash_d      = drive ? wdata : {DATA_W{1'bz}};
    assign ack_o        = (state == ACK) && cyc_i && stb_i;

    // Shadow is cleared at request acceptance, so each beat simply ORs its lane in.
    always_comb begin
        merged = shadow | (32'(flash_d) << (32'(beat) * DATA_W));
    end

    always_ff @(posedge clk_bus) begin
        if (rst_bus) begin
            state      <= IDLE;
            err_o      <= 1'b0;
            dat_o      <= 32'd0;
            flash_a    <= '0;
            flash_ce_n <= 1'b1;
            flash_oe_n <= 1'b1;
            flash_we_n <= 1'b1;
            drive      <= 1'b0;
            beat       <= 2'd0;
            wait_cnt   <= '0;
            shadow     <= 32'd0;
            wdata      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cyc_i && stb_i) begin
                        if (!we_i) begin
                            state      <= RD;
                            beat       <= 2'd0;
                            wait_cnt   <= CNT_W'(READ_WAIT - 1);
                            flash_a    <= {adr_i[ADDR_W-1:2], 2'b00};
                            flash_ce_n <= 1'b0;
                            flash_oe_n <= 1'b0;
                            shadow     <= 32'd0;
                        end else if (WRITE_EN == 0 || (DATA_W == 16 && adr_i[0])) begin
                            state <= ERR;
                            err_o <= 1'b1;
                        end else begin
                            state      <= WR_SETUP;
                            flash_a    <= adr_i[ADDR_W-1:0];
                            wdata      <= dat_i[DATA_W-1:0];
                            flash_ce_n <= 1'b0;
                            drive      <= 1'b1;
                        end
                    end
                end
                RD: begin
                    if (!cyc_i) begin
                        state      <= IDLE;
                        flash_ce_n <= 1'b1;
                        flash_oe_n <= 1'b1;
                    end else if (wait_cnt != '0) begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end else begin
                        shadow <= merged;
                        if (beat == 2'(BEATS - 1)) begin
                            state      <= ACK;
                            dat_o      <= merged;
                            flash_ce_n <= 1'b1;
                            flash_oe_n <= 1'b1;
                        end else begin
                            // ce_n/oe_n stay low; only the address moves to the next lane
                            beat     <= beat + 1'b1;
                            flash_a  <= flash_a + ADDR_W'(STEP);
                            wait_cnt <= CNT_W'(READ_WAIT - 1);
                        end
                    end
                end
                WR_SETUP: begin
                    state      <= WR_PULSE;
                    flash_we_n <= 1'b0;
                    wait_cnt   <= CNT_W'(WRITE_WAIT - 1);
                end
                WR_PULSE: begin
                    if (wait_cnt != '0) begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end else begin
                        state      <= WR_HOLD;
                        flash_we_n <= 1'b1;
                    end
                end
                WR_HOLD: begin
                    state      <= ACK;
                    flash_ce_n <= 1'b1;
                    drive      <= 1'b0;
                end
                ACK: begin
                    state <= IDLE;
                end
                ERR: begin
                    state <= IDLE;
                    err_o <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
